usbh_nes_joy_serializer: RTL

USBH_NES_JOY_SERIALIZER -- requirements
Module: usbh_nes_joy_serializer

---
 rtl/usbh_nes_joy_serializer.sv | 107 ++++++++++
 1 files changed

// File: rtl/usbh_nes_joy_serializer.sv
// NES controller-port emulation: buttons from USB HID are latched on strobe and
// shifted out one bit per read, with optional autofire gating on A and B.
`default_nettype none

module usbh_nes_joy_serializer #(
  parameter int c_clk_hz      = 6000000,
  parameter int c_autofire_hz = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_btn,
  input  logic       i_btn_valid,
  input  logic       i_autofire_a,
  input  logic       i_autofire_b,
  input  logic       i_strobe,
  input  logic       i_read,
  output logic       o_data
);

  localparam int div_raw = c_clk_hz / (2 * c_autofire_hz);
  localparam int div     = (div_raw < 1) ? 1 : div_raw;
  localparam int af_w    = (div > 1) ? $clog2(div) : 1;
  localparam logic [af_w-1:0] af_last = af_w'(div - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [7:0]      btn_r;
  logic [af_w-1:0] af_cnt;
  logic            phase;
  logic [7:0]      eff;

  state_t          state, state_next;
  logic [7:0]      sr, sr_next;
  logic [3:0]      cnt, cnt_next;
  logic            data_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_r  <= 8'h00;
      af_cnt <= '0;
      phase  <= 1'b0;
    end else begin
      if (i_btn_valid) btn_r <= i_btn;
      if (af_cnt == af_last) begin
        af_cnt <= '0;
        phase  <= ~phase;
      end else begin
        af_cnt <= af_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    eff    = btn_r;
    eff[0] = btn_r[0] & (~i_autofire_a | phase);
    eff[1] = btn_r[1] & (~i_autofire_b | phase);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_SHIFT;
      sr     <= 8'h00;
      cnt    <= 4'd0;
      o_data <= 1'b0;
    end else begin
      state  <= state_next;
      sr     <= sr_next;
      cnt    <= cnt_next;
      o_data <= data_next;
    end
  end

  // Strobe overrides every state; the falling edge only changes state, never reloads.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    data_next  = o_data;
    if (i_strobe) begin
      state_next = ST_LOAD;
      sr_next    = eff;
      cnt_next   = 4'd0;
      data_next  = eff[0];
    end else begin
      case (state)
        ST_LOAD: state_next = ST_SHIFT;
        ST_SHIFT: begin
          if (i_read) begin
            sr_next   = {1'b1, sr[7:1]};
            cnt_next  = cnt + 4'd1;
            data_next = sr[1];
            if (cnt == 4'd7) state_next = ST_DONE;
          end
        end
        ST_DONE:  data_next = 1'b1;
        default:  state_next = ST_SHIFT;
      endcase
    end
  end

endmodule

`default_nettype wire
